// File: rtl/cpu_run_ctrl_if.sv
// Board-side control bundle for the CPU run/step/halt sequencer.
// master: board/host side driving switches and buttons; slave: the sequencer.
interface cpu_run_ctrl_if;
    logic        sw_run;
    logic        btn_step;
    logic        btn_clr;
    logic [1:0]  speed;
    logic        halt_in;
    logic        scan_en;
    logic [9:0]  scan_base;
    logic        cpu_ce;
    logic        cpu_rst;
    logic [2:0]  state_o;
    logic [9:0]  ram_display_addr;
    logic [31:0] cycle_cnt;

    modport master (
        output sw_run, btn_step, btn_clr, speed, halt_in, scan_en, scan_base,
        input  cpu_ce, cpu_rst, state_o, ram_display_addr, cycle_cnt
    );

    modport slave (
        input  sw_run, btn_step, btn_clr, speed, halt_in, scan_en, scan_base,
        output cpu_ce, cpu_rst, state_o, ram_display_addr, cycle_cnt
    );
endinterface

// File: rtl/cpu_run_ctrl.sv
// Run/step/halt sequencer for the board MIPS core: issues a one-cycle CPU
// clock enable at a selectable rate, holds CPU reset after reset/clear and
// scans the data-RAM display address.
// Optional feature macro: CPU_CYCLE_COUNT_EN (saturating cpu_ce pulse counter).
module cpu_run_ctrl #(
    parameter int unsigned RST_CYC  = 16,
    parameter int unsigned DIV_W    = 24,
    parameter int unsigned SCAN_LEN = 8,
    parameter int unsigned SCAN_DIV = 20
) (
    input  logic           clk,
    input  logic           rst_n,
    cpu_run_ctrl_if.slave  ctrl
);
    localparam int unsigned HOLD_W = $clog2(RST_CYC + 1);
    localparam int unsigned IDX_W  = (SCAN_LEN > 1) ? $clog2(SCAN_LEN) : 1;
    localparam int unsigned ADDR_W = 10;

    typedef enum logic [2:0] {
        ST_RST_HOLD = 3'd0,
        ST_IDLE     = 3'd1,
        ST_RUN      = 3'd2,
        ST_STEP     = 3'd3,
        ST_HALT     = 3'd4
    } state_e;

    state_e              state_q, state_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [DIV_W-1:0]    div_q, div_d, div_last;
    logic [1:0]          speed_q;
    logic                step_q;
    logic                step_rise;
    logic                cpu_ce_q, ce_d;
    logic                cpu_rst_q;
    logic [SCAN_DIV-1:0] scan_div_q, scan_div_d;
    logic [IDX_W-1:0]    scan_idx_q, scan_idx_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;

    assign step_rise = ctrl.btn_step & ~step_q;

    // Terminal divider count (period - 1) for the selected speed.
    always_comb begin
        div_last = '1;
        case (ctrl.speed)
            2'd0:    div_last = '0;
            2'd1:    div_last = DIV_W'(8'hFF);
            2'd2:    div_last = DIV_W'(16'hFFFF);
            default: div_last = '1;
        endcase
    end

    // Next state, hold counter, divider and clock-enable decision.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        div_d   = div_q;
        ce_d    = 1'b0;
        if (ctrl.btn_clr) begin
            state_d = ST_RST_HOLD;
            hold_d  = '0;
        end else begin
            case (state_q)
                ST_RST_HOLD: begin
                    if (hold_q == HOLD_W'(RST_CYC - 1)) begin
                        state_d = ST_IDLE;
                        hold_d  = '0;
                    end else begin
                        hold_d = hold_q + HOLD_W'(1);
                    end
                end
                ST_IDLE: begin
                    if (ctrl.halt_in) begin
                        state_d = ST_HALT;
                    end else if (ctrl.sw_run) begin
                        state_d = ST_RUN;
                        div_d   = '0;
                    end else if (step_rise) begin
                        state_d = ST_STEP;
                        ce_d    = 1'b1;
                    end
                end
                ST_RUN: begin
                    if (ctrl.halt_in) begin
                        state_d = ST_HALT;
                    end else if (!ctrl.sw_run) begin
                        state_d = ST_IDLE;
                    end else if (ctrl.speed != speed_q) begin
                        div_d = '0;
                    end else if (div_q == div_last) begin
                        div_d = '0;
                        ce_d  = 1'b1;
                    end else begin
                        div_d = div_q + DIV_W'(1);
                    end
                end
                ST_STEP: begin
                    state_d = ctrl.halt_in ? ST_HALT : ST_IDLE;
                end
                ST_HALT: begin
                    state_d = ST_HALT;
                end
                default: begin
                    state_d = ST_RST_HOLD;
                    hold_d  = '0;
                end
            endcase
        end
    end

    // Sequencer registers; cpu_rst follows the state being entered.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_RST_HOLD;
            hold_q    <= '0;
            div_q     <= '0;
            speed_q   <= '0;
            step_q    <= 1'b0;
            cpu_ce_q  <= 1'b0;
            cpu_rst_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            div_q     <= div_d;
            speed_q   <= ctrl.speed;
            step_q    <= ctrl.btn_step;
            cpu_ce_q  <= ce_d;
            cpu_rst_q <= (state_d == ST_RST_HOLD);
        end
    end

    // Display scanner: step period 2**SCAN_DIV, index wraps at SCAN_LEN.
    always_comb begin
        scan_div_d = scan_div_q;
        scan_idx_d = scan_idx_q;
        if (!ctrl.scan_en) begin
            scan_div_d = '0;
            scan_idx_d = '0;
        end else if (scan_div_q == '1) begin
            scan_div_d = '0;
            scan_idx_d = (scan_idx_q == IDX_W'(SCAN_LEN - 1)) ? '0 : scan_idx_q + IDX_W'(1);
        end else begin
            scan_div_d = scan_div_q + SCAN_DIV'(1);
        end
        addr_d = ctrl.scan_base + ADDR_W'(scan_idx_d);
    end

    // Scanner registers, independent of the sequencer state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scan_div_q <= '0;
            scan_idx_q <= '0;
            addr_q     <= ctrl.scan_base;
        end else begin
            scan_div_q <= scan_div_d;
            scan_idx_q <= scan_idx_d;
            addr_q     <= addr_d;
        end
    end

`ifdef CPU_CYCLE_COUNT_EN
    logic [31:0] cyc_q, cyc_d;

    // Saturating count of issued enables, cleared while CPU reset is held.
    always_comb begin
        cyc_d = cyc_q;
        if (state_d == ST_RST_HOLD) begin
            cyc_d = '0;
        end else if (ce_d && (cyc_q != '1)) begin
            cyc_d = cyc_q + 32'd1;
        end
    end

    // Cycle counter register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cyc_q <= '0;
        end else begin
            cyc_q <= cyc_d;
        end
    end

    assign ctrl.cycle_cnt = cyc_q;
`else
    assign ctrl.cycle_cnt = 32'd0;
`endif

    assign ctrl.cpu_ce           = cpu_ce_q;
    assign ctrl.cpu_rst          = cpu_rst_q;
    assign ctrl.state_o          = state_q;
    assign ctrl.ram_display_addr = addr_q;
endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl: reset hold, single step, free run rates,
// speed change, run drop on a due tick, halt/clear and display scanning.
module tb_cpu_run_ctrl;
`ifdef CPU_CYCLE_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    cpu_run_ctrl_if bus ();

    cpu_run_ctrl #(.SCAN_DIV(2)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ctrl  (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    // Pulse btn_clr for one cycle, then count cycles with cpu_rst high.
    task automatic do_clear(output int n, output logic [2:0] st0, output logic rst0);
        bus.btn_clr = 1'b1;
        @(negedge clk);
        st0  = bus.state_o;
        rst0 = bus.cpu_rst;
        bus.btn_clr = 1'b0;
        n = 0;
        while (bus.cpu_rst && n < 100) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        int n;
        bus.sw_run = 0; bus.btn_step = 0; bus.btn_clr = 0; bus.speed = 2'd0;
        bus.halt_in = 0; bus.scan_en = 0; bus.scan_base = 10'h3FE;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (bus.state_o !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", bus.state_o); end
        checks++; if (bus.cpu_rst !== 1'b1) begin errors++; $display("FAIL reset_cpu_rst: got %b expected 1", bus.cpu_rst); end
        checks++; if (bus.cpu_ce !== 1'b0) begin errors++; $display("FAIL reset_cpu_ce: got %b expected 0", bus.cpu_ce); end
        checks++; if (bus.cycle_cnt !== 32'd0) begin errors++; $display("FAIL reset_cycle_cnt: got %0d expected 0", bus.cycle_cnt); end
        checks++; if (bus.ram_display_addr !== 10'h3FE) begin errors++; $display("FAIL reset_addr: got %h expected 3fe", bus.ram_display_addr); end
        rst_n = 1'b1;
        n = 0;
        while (bus.cpu_rst && n < 100) begin
            n++;
            @(negedge clk);
        end
        checks++; if (n != 16) begin errors++; $display("FAIL reset_hold_len: got %0d expected 16", n); end
        checks++; if (bus.state_o !== 3'd1) begin errors++; $display("FAIL reset_to_idle: got %0d expected 1", bus.state_o); end
        checks++; if (bus.cpu_ce !== 1'b0) begin errors++; $display("FAIL reset_idle_ce: got %b expected 0", bus.cpu_ce); end
    endtask

    task automatic test_step;
        int pulses = 0;
        bus.btn_step = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.cpu_ce) begin
                pulses++;
                checks++; if (bus.state_o !== 3'd3) begin errors++; $display("FAIL step_state: got %0d expected 3", bus.state_o); end
            end
        end
        bus.btn_step = 1'b0;
        @(negedge clk);
        checks++; if (pulses != 1) begin errors++; $display("FAIL step_pulses: got %0d expected 1", pulses); end
        checks++; if (bus.state_o !== 3'd1) begin errors++; $display("FAIL step_back_idle: got %0d expected 1", bus.state_o); end
        checks++; if (bus.cycle_cnt !== (CNT_EN ? 32'd1 : 32'd0)) begin errors++; $display("FAIL step_cycle_cnt: got %0d expected %0d", bus.cycle_cnt, CNT_EN ? 1 : 0); end
    endtask

    task automatic test_run_speed1;
        int n, pulses, first, last;
        logic [2:0] st0;
        logic rst0;
        bus.sw_run = 1'b0;
        bus.speed  = 2'd1;
        do_clear(n, st0, rst0);
        checks++; if (n != 16) begin errors++; $display("FAIL run_clear_hold: got %0d expected 16", n); end
        bus.sw_run = 1'b1;
        @(negedge clk);
        checks++; if (bus.state_o !== 3'd2) begin errors++; $display("FAIL run_enter: got %0d expected 2", bus.state_o); end
        checks++; if (bus.cpu_ce !== 1'b0) begin errors++; $display("FAIL run_enter_ce: got %b expected 0", bus.cpu_ce); end
        pulses = 0; first = 0; last = 0;
        for (int k = 1; k <= 1024; k++) begin
            @(negedge clk);
            if (bus.cpu_ce) begin
                pulses++;
                if (first == 0) first = k;
                last = k;
            end
        end
        checks++; if (pulses != 4) begin errors++; $display("FAIL run_pulses: got %0d expected 4", pulses); end
        checks++; if (first != 256) begin errors++; $display("FAIL run_first_tick: got %0d expected 256", first); end
        checks++; if (last != 1024) begin errors++; $display("FAIL run_last_tick: got %0d expected 1024", last); end
        checks++; if (bus.cycle_cnt !== (CNT_EN ? 32'd4 : 32'd0)) begin errors++; $display("FAIL run_cycle_cnt: got %0d expected %0d", bus.cycle_cnt, CNT_EN ? 4 : 0); end
    endtask

    task automatic test_speed_change_and_stop;
        int pulses;
        bus.speed = 2'd0;
        @(negedge clk);
        checks++; if (bus.cpu_ce !== 1'b0) begin errors++; $display("FAIL speed_change_ce: got %b expected 0", bus.cpu_ce); end
        pulses = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (bus.cpu_ce) pulses++;
        end
        checks++; if (pulses != 5) begin errors++; $display("FAIL speed0_every_cycle: got %0d expected 5", pulses); end
        bus.speed = 2'd1;
        @(negedge clk);
        checks++; if (bus.cpu_ce !== 1'b0) begin errors++; $display("FAIL speed_change2_ce: got %b expected 0", bus.cpu_ce); end
        pulses = 0;
        for (int k = 1; k <= 255; k++) begin
            @(negedge clk);
            if (bus.cpu_ce) pulses++;
        end
        checks++; if (pulses != 0) begin errors++; $display("FAIL speed1_quiet: got %0d expected 0", pulses); end
        bus.sw_run = 1'b0;
        @(negedge clk);
        checks++; if (bus.cpu_ce !== 1'b0) begin errors++; $display("FAIL stop_due_ce: got %b expected 0", bus.cpu_ce); end
        checks++; if (bus.state_o !== 3'd1) begin errors++; $display("FAIL stop_state: got %0d expected 1", bus.state_o); end
    endtask

    task automatic test_halt;
        int n, pulses;
        logic [2:0] st0;
        logic rst0;
        bus.speed  = 2'd0;
        bus.sw_run = 1'b1;
        @(negedge clk);
        checks++; if (bus.state_o !== 3'd2) begin errors++; $display("FAIL halt_run_enter: got %0d expected 2", bus.state_o); end
        pulses = 0;
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            if (bus.cpu_ce) pulses++;
        end
        checks++; if (pulses != 9) begin errors++; $display("FAIL halt_pre_run: got %0d expected 9", pulses); end
        bus.halt_in = 1'b1;
        @(negedge clk);
        checks++; if (bus.cpu_ce !== 1'b0) begin errors++; $display("FAIL halt_ce: got %b expected 0", bus.cpu_ce); end
        checks++; if (bus.state_o !== 3'd4) begin errors++; $display("FAIL halt_state: got %0d expected 4", bus.state_o); end
        pulses = 0;
        bus.btn_step = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (k == 5) bus.btn_step = 1'b0;
            if (bus.cpu_ce) pulses++;
        end
        checks++; if (pulses != 0) begin errors++; $display("FAIL halt_quiet: got %0d expected 0", pulses); end
        checks++; if (bus.state_o !== 3'd4) begin errors++; $display("FAIL halt_stays: got %0d expected 4", bus.state_o); end
        bus.sw_run  = 1'b0;
        bus.halt_in = 1'b0;
        do_clear(n, st0, rst0);
        checks++; if (st0 !== 3'd0) begin errors++; $display("FAIL clear_state: got %0d expected 0", st0); end
        checks++; if (rst0 !== 1'b1) begin errors++; $display("FAIL clear_cpu_rst: got %b expected 1", rst0); end
        checks++; if (n != 16) begin errors++; $display("FAIL clear_hold_len: got %0d expected 16", n); end
        checks++; if (bus.state_o !== 3'd1) begin errors++; $display("FAIL clear_to_idle: got %0d expected 1", bus.state_o); end
        checks++; if (bus.cycle_cnt !== 32'd0) begin errors++; $display("FAIL clear_cycle_cnt: got %0d expected 0", bus.cycle_cnt); end
    endtask

    task automatic test_scan;
        logic [9:0] base;
        logic [9:0] exp_addr;
        int idx;
        base = 10'h3FE;
        bus.scan_base = base;
        bus.scan_en   = 1'b1;
        for (int k = 0; k <= 40; k++) begin
            @(negedge clk);
            idx = ((k + 1) / 4) % 8;
            exp_addr = base + 10'(idx);
            checks++; if (bus.ram_display_addr !== exp_addr) begin errors++; $display("FAIL scan_addr k=%0d: got %h expected %h", k, bus.ram_display_addr, exp_addr); end
        end
        bus.scan_en = 1'b0;
        @(negedge clk);
        checks++; if (bus.ram_display_addr !== 10'h3FE) begin errors++; $display("FAIL scan_off: got %h expected 3fe", bus.ram_display_addr); end
        bus.scan_base = 10'h100;
        @(negedge clk);
        checks++; if (bus.ram_display_addr !== 10'h100) begin errors++; $display("FAIL scan_base_change: got %h expected 100", bus.ram_display_addr); end
    endtask

    initial begin
        test_reset();
        test_step();
        test_run_speed1();
        test_speed_change_and_stop();
        test_halt();
        test_scan();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
